serial_link_obi_tx_fifo: RTL and testbench

// Transmit-side counterpart of the serial-link RX FIFO path: an OBI slave buffers 32-bit words in a TX FIFO
// and an AXI4 write master drains them into the serial link axi_in port, one single-beat burst at a time.

---
 rtl/serial_link_tx_pkg.sv | 21 ++
 rtl/serial_link_tx_fifo.sv | 50 +++++
 rtl/serial_link_obi_tx_fifo.sv | 181 ++++++++++++++++++
 tb/tb_serial_link_obi_tx_fifo.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_tx_pkg.sv
// Shared definitions for the serial-link OBI-to-AXI transmit path.
// Register map, FSM encoding and AXI response codes.
package serial_link_tx_pkg;

    localparam logic [1:0] RegData   = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegDest   = 2'd2;
    localparam logic [1:0] RegCtrl   = 2'd3;

    localparam logic [1:0] AxiRespOkay   = 2'b00;
    localparam logic [1:0] AxiRespExOkay = 2'b01;
    localparam logic [1:0] AxiRespSlvErr = 2'b10;
    localparam logic [1:0] AxiRespDecErr = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RESP
    } fsm_e;

endpackage

// File: rtl/serial_link_tx_fifo.sv
// Synchronous FIFO holding {strb, data} payloads for the TX path.
// Pointers wrap naturally because Depth is a power of two.
module serial_link_tx_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 36
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     fill_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [PtrW:0]    fill_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            fill_q <= fill_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign full_o  = (fill_q == (PtrW+1)'(Depth));
    assign empty_o = (fill_q == '0);
    assign fill_o  = fill_q;

endmodule

// File: rtl/serial_link_obi_tx_fifo.sv
// OBI slave that buffers words and ships each as a single-beat AXI write
// into the serial link; one outstanding transaction at a time.
module serial_link_obi_tx_fifo
    import serial_link_tx_pkg::*;
#(
    parameter int unsigned FifoDepth = 8,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 obi_req_i,
    output logic                 obi_gnt_o,
    input  logic [AddrWidth-1:0] obi_addr_i,
    input  logic                 obi_we_i,
    input  logic [3:0]           obi_be_i,
    input  logic [DataWidth-1:0] obi_wdata_i,
    output logic                 obi_rvalid_o,
    output logic [DataWidth-1:0] obi_rdata_o,
    output logic                 aw_valid_o,
    input  logic                 aw_ready_i,
    output logic [AddrWidth-1:0] aw_addr_o,
    output logic                 w_valid_o,
    input  logic                 w_ready_i,
    output logic [DataWidth-1:0] w_data_o,
    output logic [3:0]           w_strb_o,
    output logic                 w_last_o,
    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    input  logic [1:0]           b_resp_i,
    output logic                 irq_empty_o
);
    localparam int unsigned FillW = $clog2(FifoDepth) + 1;
    localparam int unsigned PayW  = DataWidth + 4;

    logic [1:0]           sel;
    logic                 gnt, data_wr, dest_wr, ctrl_wr;
    logic                 full, empty, pop;
    logic [FillW-1:0]     fill;
    logic [PayW-1:0]      head;
    logic                 b_hs, b_err;
    logic                 unused_addr;

    fsm_e                 state_q, state_d;
    logic [AddrWidth-1:0] dest_q, cur_addr_q, cur_addr_d, aw_addr_q;
    logic [DataWidth-1:0] w_data_q, rdata_q, rdata_d;
    logic [3:0]           w_strb_q;
    logic                 aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
    logic                 en_q, autoinc_q, err_q, err_d;
    logic                 reload_q, rvalid_q;

    assign sel         = obi_addr_i[3:2];
    assign unused_addr = ^{obi_addr_i[AddrWidth-1:4], obi_addr_i[1:0]};

    assign gnt     = obi_req_i & ~(obi_we_i & (sel == RegData) & full);
    assign data_wr = gnt & obi_we_i & (sel == RegData);
    assign dest_wr = gnt & obi_we_i & (sel == RegDest);
    assign ctrl_wr = gnt & obi_we_i & (sel == RegCtrl);

    serial_link_tx_fifo #(
        .Depth (FifoDepth),
        .Width (PayW)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (data_wr),
        .data_i  ({obi_be_i, obi_wdata_i}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .fill_o  (fill)
    );

    always_comb begin
        rdata_d = '0;
        if (gnt & ~obi_we_i) begin
            unique case (sel)
                RegStatus: begin
                    rdata_d[FillW-1:0] = fill;
                    rdata_d[16]        = full;
                    rdata_d[17]        = empty;
                    rdata_d[18]        = err_q;
                end
                RegDest: rdata_d      = DataWidth'(dest_q);
                RegCtrl: rdata_d[1:0] = {autoinc_q, en_q};
                default: rdata_d      = '0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_q & ~empty) begin
                    pop        = 1'b1;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (aw_ready_i) aw_valid_d = 1'b0;
                if (w_ready_i)  w_valid_d  = 1'b0;
                if (~aw_valid_d & ~w_valid_d) state_d = RESP;
            end
            RESP: begin
                if (b_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign b_hs  = (state_q == RESP) & b_valid_i;
    assign b_err = b_hs & (b_resp_i != AxiRespOkay);
    assign err_d = b_err | (err_q & ~(ctrl_wr & obi_wdata_i[2]));

    // A DEST write since the last pop overrides the post-response increment
    always_comb begin
        cur_addr_d = cur_addr_q;
        if (dest_wr) begin
            cur_addr_d = AddrWidth'(obi_wdata_i);
        end else if (b_hs & autoinc_q & ~reload_q) begin
            cur_addr_d = cur_addr_q + AddrWidth'(4);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            dest_q     <= '0;
            cur_addr_q <= '0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            en_q       <= 1'b0;
            autoinc_q  <= 1'b0;
            err_q      <= 1'b0;
            reload_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            cur_addr_q <= cur_addr_d;
            err_q      <= err_d;
            reload_q   <= dest_wr | (reload_q & ~pop);
            rvalid_q   <= gnt;
            rdata_q    <= rdata_d;
            if (dest_wr) dest_q <= AddrWidth'(obi_wdata_i);
            if (ctrl_wr) begin
                en_q      <= obi_wdata_i[0];
                autoinc_q <= obi_wdata_i[1];
            end
            if (pop) begin
                aw_addr_q              <= cur_addr_q;
                {w_strb_q, w_data_q}   <= head;
            end
        end
    end

    assign obi_gnt_o    = gnt;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign aw_valid_o   = aw_valid_q;
    assign aw_addr_o    = aw_addr_q;
    assign w_valid_o    = w_valid_q;
    assign w_data_o     = w_data_q;
    assign w_strb_o     = w_strb_q;
    assign w_last_o     = w_valid_q;
    assign b_ready_o    = (state_q == RESP);
    assign irq_empty_o  = empty & (state_q == IDLE);

endmodule

// File: tb/tb_serial_link_obi_tx_fifo.sv
// Directed bench for the OBI-to-AXI TX FIFO: register access, ordering,
// back-pressure, error reporting, DEST reload and reset abort.
module tb_serial_link_obi_tx_fifo;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        obi_req_i = 1'b0;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i = '0;
    logic        obi_we_i = 1'b0;
    logic [3:0]  obi_be_i = '0;
    logic [31:0] obi_wdata_i = '0;
    logic        obi_rvalid_o;
    logic [31:0] obi_rdata_o;
    logic        aw_valid_o;
    logic        aw_ready_i = 1'b1;
    logic [31:0] aw_addr_o;
    logic        w_valid_o;
    logic        w_ready_i = 1'b1;
    logic [31:0] w_data_o;
    logic [3:0]  w_strb_o;
    logic        w_last_o;
    logic        b_valid_i;
    logic        b_ready_o;
    logic [1:0]  b_resp_i;
    logic        irq_empty_o;

    int checks = 0;
    int errors = 0;
    int bhs = 0;
    int err_idx = -1;
    logic b_en = 1'b1;
    logic [31:0] aw_log[$];
    logic [35:0] w_log[$];

    always #5 clk = ~clk;

    assign b_valid_i = b_ready_o & b_en;
    assign b_resp_i  = (bhs == err_idx) ? 2'b10 : 2'b00;

    serial_link_obi_tx_fifo dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rdata_o  (obi_rdata_o),
        .aw_valid_o   (aw_valid_o),
        .aw_ready_i   (aw_ready_i),
        .aw_addr_o    (aw_addr_o),
        .w_valid_o    (w_valid_o),
        .w_ready_i    (w_ready_i),
        .w_data_o     (w_data_o),
        .w_strb_o     (w_strb_o),
        .w_last_o     (w_last_o),
        .b_valid_i    (b_valid_i),
        .b_ready_o    (b_ready_o),
        .b_resp_i     (b_resp_i),
        .irq_empty_o  (irq_empty_o)
    );

    always @(negedge clk) begin
        if (!rst_i) begin
            if (aw_valid_o && aw_ready_i) aw_log.push_back(aw_addr_o);
            if (w_valid_o && w_ready_i) w_log.push_back({w_strb_o, w_data_o});
        end
    end

    always @(posedge clk) begin
        if (!rst_i && b_valid_i && b_ready_o) bhs <= bhs + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic obi_xfer(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output logic [31:0] rdata);
        int n;
        @(posedge clk); #1;
        obi_req_i   = 1'b1;
        obi_we_i    = we;
        obi_addr_i  = addr;
        obi_wdata_i = wdata;
        obi_be_i    = be;
        n = 0;
        @(negedge clk);
        while (!obi_gnt_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("obi_gnt", obi_gnt_o, 1);
        @(posedge clk); #1;
        obi_req_i = 1'b0;
        obi_we_i  = 1'b0;
        chk("obi_rvalid", obi_rvalid_o, 1);
        rdata = obi_rdata_o;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d,
                      input logic [3:0] be);
        logic [31:0] rd;
        obi_xfer(1'b1, addr, d, be, rd);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp);
        logic [31:0] rd;
        obi_xfer(1'b0, addr, '0, 4'hF, rd);
        chk(tag, rd, exp);
    endtask

    task automatic wait_n(input int target);
        int n;
        n = 0;
        while (!(bhs >= target && irq_empty_o) && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("drain_done", (bhs >= target && irq_empty_o), 1);
    endtask

    task automatic wait_aw();
        int n;
        n = 0;
        @(negedge clk);
        while (!aw_valid_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("aw_valid_seen", aw_valid_o, 1);
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        @(negedge clk);
        chk("rst_irq_empty", irq_empty_o, 1);
        chk("rst_aw_valid", aw_valid_o, 0);
        chk("rst_w_valid", w_valid_o, 0);
        chk("rst_b_ready", b_ready_o, 0);
        chk("rst_rvalid", obi_rvalid_o, 0);
        rd_chk("rst_status", 32'h4, 32'h0002_0000);
        rd_chk("rst_ctrl", 32'hC, 32'h0);
        rd_chk("rst_dest", 32'h8, 32'h0);

        // Autoincrement ordering and push-to-AW latency
        wr(32'h8, 32'h1000, 4'hF);
        wr(32'hC, 32'h3, 4'hF);
        wr(32'h0, 32'hA000_0001, 4'hF);
        @(negedge clk);
        chk("lat_aw_early", aw_valid_o, 0);
        @(negedge clk);
        chk("lat_aw_valid", aw_valid_o, 1);
        chk("lat_w_valid", w_valid_o, 1);
        chk("lat_w_last", w_last_o, 1);
        wr(32'h0, 32'hA000_0002, 4'h3);
        wr(32'h0, 32'hA000_0003, 4'hC);
        wait_n(3);
        chk("t1_aw_cnt", aw_log.size(), 3);
        chk("t1_aw0", aw_log[0], 32'h1000);
        chk("t1_aw1", aw_log[1], 32'h1004);
        chk("t1_aw2", aw_log[2], 32'h1008);
        chk("t1_w0", w_log[0], 36'hF_A000_0001);
        chk("t1_w1", w_log[1], 36'h3_A000_0002);
        chk("t1_w2", w_log[2], 36'hC_A000_0003);
        chk("t1_irq", irq_empty_o, 1);

        // Fill to full with the engine disabled, then release
        wr(32'hC, 32'h0, 4'hF);
        for (int i = 0; i < 8; i++) wr(32'h0, 32'hB0 + i, 4'hF);
        rd_chk("t2_status_full", 32'h4, 32'h0001_0008);
        @(posedge clk); #1;
        obi_req_i = 1'b1; obi_we_i = 1'b1; obi_addr_i = 32'h0;
        obi_wdata_i = 32'hB8; obi_be_i = 4'hF;
        repeat (3) begin
            @(negedge clk);
            chk("t2_stall_gnt", obi_gnt_o, 0);
        end
        @(posedge clk); #1;
        obi_req_i = 1'b0; obi_we_i = 1'b0;
        base = aw_log.size();
        wr(32'hC, 32'h1, 4'hF);
        obi_req_i = 1'b1; obi_we_i = 1'b1; obi_addr_i = 32'h0;
        obi_wdata_i = 32'hB8; obi_be_i = 4'hF;
        @(negedge clk);
        chk("t2_gnt_before_pop", obi_gnt_o, 0);
        @(negedge clk);
        chk("t2_gnt_after_pop", obi_gnt_o, 1);
        @(posedge clk); #1;
        obi_req_i = 1'b0; obi_we_i = 1'b0;
        chk("t2_rvalid", obi_rvalid_o, 1);
        wait_n(12);
        chk("t2_aw_cnt", aw_log.size() - base, 9);
        chk("t2_aw_first", aw_log[base], 32'h100C);
        chk("t2_aw_last", aw_log[base+8], 32'h100C);
        chk("t2_w_first", w_log[base], 36'hF_0000_00B0);
        chk("t2_w_last", w_log[base+8], 36'hF_0000_00B8);

        // AW back-pressure with W accepted immediately
        aw_ready_i = 1'b0;
        wr(32'h0, 32'hC0, 4'hF);
        wait_aw();
        chk("t3_w_valid_s0", w_valid_o, 1);
        chk("t3_b_ready_s0", b_ready_o, 0);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("t3_aw_hold", aw_valid_o, 1);
            chk("t3_w_dropped", w_valid_o, 0);
            chk("t3_b_ready_wait", b_ready_o, 0);
        end
        @(posedge clk); #1;
        aw_ready_i = 1'b1;
        @(negedge clk);
        chk("t3_aw_last", aw_valid_o, 1);
        @(negedge clk);
        chk("t3_aw_gone", aw_valid_o, 0);
        chk("t3_b_ready", b_ready_o, 1);
        wait_n(13);

        // Error response on the middle word
        base = aw_log.size();
        err_idx = bhs + 1;
        for (int i = 0; i < 3; i++) wr(32'h0, 32'hD0 + i, 4'hF);
        wait_n(16);
        chk("t4_all_sent", aw_log.size() - base, 3);
        rd_chk("t4_status_err", 32'h4, 32'h0006_0000);
        wr(32'hC, 32'h5, 4'hF);
        rd_chk("t4_status_clr", 32'h4, 32'h0002_0000);
        rd_chk("t4_ctrl", 32'hC, 32'h1);
        err_idx = -1;

        // Fixed address, then DEST reload while a response is pending
        base = aw_log.size();
        wr(32'h8, 32'h2000, 4'hF);
        for (int i = 0; i < 4; i++) wr(32'h0, 32'hE0 + i, 4'hF);
        wait_n(20);
        for (int i = 0; i < 4; i++) chk("t5_aw_fixed", aw_log[base+i], 32'h2000);
        base = aw_log.size();
        b_en = 1'b0;
        wr(32'h0, 32'hF0, 4'hF);
        wr(32'h0, 32'hF1, 4'hF);
        chk("t5_in_resp", b_ready_o, 1);
        wr(32'h8, 32'h3000, 4'hF);
        b_en = 1'b1;
        wait_n(22);
        chk("t5_aw_old", aw_log[base], 32'h2000);
        chk("t5_aw_new", aw_log[base+1], 32'h3000);
        rd_chk("t5_dest", 32'h8, 32'h3000);

        // Reset while stuck in SEND
        aw_ready_i = 1'b0;
        wr(32'h0, 32'h11, 4'hF);
        wr(32'h0, 32'h22, 4'hF);
        wait_aw();
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        aw_ready_i = 1'b1;
        @(negedge clk);
        chk("t6_aw_valid", aw_valid_o, 0);
        chk("t6_w_valid", w_valid_o, 0);
        chk("t6_irq", irq_empty_o, 1);
        rd_chk("t6_status", 32'h4, 32'h0002_0000);
        rd_chk("t6_ctrl", 32'hC, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
